// File: rtl/key_sw_io_if.sv
// Processor load/store port into the KEY/SW register window.
// The master drives the address and strobes; the slave returns hit and read data.
interface key_sw_io_if #(
  parameter int unsigned DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic             rdEn;
  logic             wrEn;
  logic [DBITS-1:0] wdata;
  logic             hit;
  logic [DBITS-1:0] rdata;

  modport master (
    output addr,
    output rdEn,
    output wrEn,
    output wdata,
    input  hit,
    input  rdata
  );

  modport slave (
    input  addr,
    input  rdEn,
    input  wrEn,
    input  wdata,
    output hit,
    output rdata
  );
endinterface

// File: rtl/key_sw_io.sv
// Memory-mapped KEY/SW input controller: sync + debounce, sticky READY/OVR status, load window.
// Optional KEYSW_IRQ_EN adds the IE bits and a registered irq output.
module key_sw_io #(
  parameter int unsigned      DBITS           = 32,
  parameter int unsigned      DEBOUNCE_CYCLES = 100000,
  parameter int unsigned      CNT_BITS        = 17,
  parameter logic [DBITS-1:0] ADDR_KDATA      = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SDATA      = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114
) (
  input  logic              clk,
  input  logic              reset,
  key_sw_io_if.slave        bus,
  input  logic [3:0]        keyRaw,
  input  logic [9:0]        swRaw
`ifdef KEYSW_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int unsigned            NBITS   = 14;
  // Pin level while nothing is pressed/switched: KEY pins idle high, SW idle low.
  localparam logic [NBITS-1:0]       IdleLvl = {10'b0, 4'hF};
  localparam logic [CNT_BITS-1:0]    CntMax  = CNT_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0]    CntOne  = CNT_BITS'(1);

  // ---------------------------------------------------------------------------------------------
  // Input synchronisers and debounce (bit 0..3 KEY, 4..13 SW)
  // ---------------------------------------------------------------------------------------------
  logic [NBITS-1:0]                meta_q, sync_q;
  logic [NBITS-1:0]                level;
  logic [NBITS-1:0]                stable_q, stable_d;
  logic [NBITS-1:0][CNT_BITS-1:0]  cnt_q, cnt_d;

  assign level = sync_q ^ IdleLvl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q   <= IdleLvl;
      sync_q   <= IdleLvl;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= {swRaw, keyRaw};
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < NBITS; i++) begin
      if (level[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = level[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
  end

  // Group 0 = KEY, group 1 = SW.
  logic [1:0] evt;
  assign evt[0] = |(stable_d[3:0]  ^ stable_q[3:0]);
  assign evt[1] = |(stable_d[13:4] ^ stable_q[13:4]);

  // ---------------------------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------------------------
  logic [1:0] data_hit, ctrl_hit;
  logic [1:0] data_load, ctrl_wr;

  assign data_hit  = {bus.addr == ADDR_SDATA, bus.addr == ADDR_KDATA};
  assign ctrl_hit  = {bus.addr == ADDR_SCTRL, bus.addr == ADDR_KCTRL};
  assign bus.hit   = |{data_hit, ctrl_hit};
  // A simultaneous store suppresses clear-on-read.
  assign data_load = {2{bus.rdEn & ~bus.wrEn}} & data_hit;
  assign ctrl_wr   = {2{bus.wrEn}} & ctrl_hit;

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata;

  // ---------------------------------------------------------------------------------------------
  // Sticky status
  // ---------------------------------------------------------------------------------------------
  logic [1:0] ready_q, ready_d;
  logic [1:0] ovr_q, ovr_d;
  logic [1:0] ie;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= '0;
      ovr_q   <= '0;
    end else begin
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    ready_d = ready_q;
    ovr_d   = ovr_q;
    for (int g = 0; g < 2; g++) begin
      if (evt[g]) begin
        ready_d[g] = 1'b1;
      end else if (data_load[g]) begin
        ready_d[g] = 1'b0;
      end
      // A clearing store beats an overrun raised on the same edge.
      if (ctrl_wr[g] && !bus.wdata[2]) begin
        ovr_d[g] = 1'b0;
      end else if (evt[g] && ready_q[g] && !data_load[g]) begin
        ovr_d[g] = 1'b1;
      end
    end
  end

`ifdef KEYSW_IRQ_EN
  logic [1:0] ie_q, ie_d;
  logic       irq_q, irq_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  always_comb begin
    ie_d = ie_q;
    for (int g = 0; g < 2; g++) begin
      if (ctrl_wr[g]) begin
        ie_d[g] = bus.wdata[8];
      end
    end
  end

  assign irq_d = |(ie_q & ready_q);
  assign ie    = ie_q;
  assign irq   = irq_q;
`else
  assign ie = 2'b00;
`endif

  // ---------------------------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    bus.rdata = '0;
    if (data_hit[0]) begin
      bus.rdata[3:0] = stable_q[3:0];
    end else if (data_hit[1]) begin
      bus.rdata[9:0] = stable_q[13:4];
    end else if (ctrl_hit[0]) begin
      bus.rdata[8:0] = {ie[0], 5'b0, ovr_q[0], 1'b0, ready_q[0]};
    end else if (ctrl_hit[1]) begin
      bus.rdata[8:0] = {ie[1], 5'b0, ovr_q[1], 1'b0, ready_q[1]};
    end
  end

endmodule

// File: tb/tb_key_sw_io.sv
// Self-checking bench for key_sw_io (DEBOUNCE_CYCLES=4): directed scenarios then random traffic,
// compared against a cycle-level behavioural model of the register map.
module tb_key_sw_io;

  localparam int unsigned DEB   = 4;
  localparam logic [31:0] KDATA = 32'hF0000010;
  localparam logic [31:0] SDATA = 32'hF0000014;
  localparam logic [31:0] KCTRL = 32'hF0000110;
  localparam logic [31:0] SCTRL = 32'hF0000114;
  localparam logic [13:0] IDLE  = 14'h00F;
`ifdef KEYSW_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] keyRaw = 4'hF;
  logic [9:0] swRaw = 10'h0;
  logic       irq;

  key_sw_io_if #(.DBITS(32)) bus ();

  key_sw_io #(
    .DBITS          (32),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_BITS       (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .keyRaw(keyRaw),
    .swRaw (swRaw)
`ifdef KEYSW_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

`ifndef KEYSW_IRQ_EN
  assign irq = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model state
  logic [13:0] m_d1, m_d2;   // pin samples one and two edges ago
  logic [13:0] m_st;         // accepted levels, pressed/on = 1
  int          m_run [14];   // consecutive edges the synced level disagreed with m_st
  bit          m_rdy [2];
  bit          m_ovr [2];
  bit          m_ie  [2];
  bit          m_irq;

  task automatic m_reset();
    m_d1 = IDLE;
    m_d2 = IDLE;
    m_st = '0;
    for (int i = 0; i < 14; i++) m_run[i] = 0;
    for (int g = 0; g < 2; g++) begin
      m_rdy[g] = 0;
      m_ovr[g] = 0;
      m_ie[g]  = 0;
    end
    m_irq = 0;
  endtask

  function automatic logic [31:0] m_read(logic [31:0] a);
    case (a)
      KDATA:   return {28'b0, m_st[3:0]};
      SDATA:   return {22'b0, m_st[13:4]};
      KCTRL:   return (32'(m_ie[0]) << 8) | (32'(m_ovr[0]) << 2) | 32'(m_rdy[0]);
      SCTRL:   return (32'(m_ie[1]) << 8) | (32'(m_ovr[1]) << 2) | 32'(m_rdy[1]);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_hit(logic [31:0] a);
    return (a == KDATA) || (a == SDATA) || (a == KCTRL) || (a == SCTRL);
  endfunction

  // Advance the model across one clock edge using the values currently driven.
  task automatic m_edge();
    logic [13:0] lvl, nst;
    bit ev [2];
    bit ld, wr, irq_n;
    lvl = m_d2 ^ IDLE;
    nst = m_st;
    for (int i = 0; i < 14; i++) begin
      if (lvl[i] != m_st[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          nst[i]   = lvl[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    ev[0] = (nst[3:0] != m_st[3:0]);
    ev[1] = (nst[13:4] != m_st[13:4]);
    irq_n = (m_ie[0] && m_rdy[0]) || (m_ie[1] && m_rdy[1]);
    for (int g = 0; g < 2; g++) begin
      ld = bus.rdEn && !bus.wrEn && (bus.addr == (g == 0 ? KDATA : SDATA));
      wr = bus.wrEn && (bus.addr == (g == 0 ? KCTRL : SCTRL));
      if (wr && !bus.wdata[2]) m_ovr[g] = 0;
      else if (ev[g] && m_rdy[g] && !ld) m_ovr[g] = 1;
      if (ev[g]) m_rdy[g] = 1;
      else if (ld) m_rdy[g] = 0;
      if (wr && IRQ_EN) m_ie[g] = bus.wdata[8];
    end
    m_irq = IRQ_EN ? irq_n : 1'b0;
    m_st  = nst;
    m_d2  = m_d1;
    m_d1  = {swRaw, keyRaw};
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // One clock: optional pre-edge check of the combinational outputs, then edge + model update.
  task automatic step(input bit do_chk, input string tag);
    #1;
    if (do_chk) begin
      chk({tag, "_rdata"}, bus.rdata, m_read(bus.addr));
      chk({tag, "_hit"}, 32'(bus.hit), 32'(m_hit(bus.addr)));
    end
    @(posedge clk);
    if (!reset) m_reset();
    else m_edge();
    #1;
    if (do_chk) chk({tag, "_irq"}, 32'(irq), 32'(m_irq));
  endtask

  task automatic idle_bus();
    bus.addr  = '0;
    bus.rdEn  = 1'b0;
    bus.wrEn  = 1'b0;
    bus.wdata = '0;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(1'b0, "");
  endtask

  task automatic peek(input string tag, input logic [31:0] a);
    bus.addr = a;
    #1;
    chk(tag, bus.rdata, m_read(a));
    bus.addr = '0;
  endtask

  task automatic peekc(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(tag, bus.rdata, exp);
    bus.addr = '0;
  endtask

  task automatic load(input logic [31:0] a);
    bus.addr = a;
    bus.rdEn = 1'b1;
    step(1'b0, "");
    idle_bus();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wrEn  = 1'b1;
    bus.wdata = d;
    step(1'b0, "");
    idle_bus();
  endtask

  logic [31:0] addrs [6];

  initial begin
    addrs[0] = KDATA; addrs[1] = SDATA; addrs[2] = KCTRL;
    addrs[3] = SCTRL; addrs[4] = 32'hF0000011; addrs[5] = 32'h0;
    idle_bus();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state and out-of-window decode
    peekc("rst_kdata", KDATA, 32'h0);
    peekc("rst_kctrl", KCTRL, 32'h0);
    peekc("rst_sdata", SDATA, 32'h0);
    peekc("rst_sctrl", SCTRL, 32'h0);
    bus.addr = 32'hF0000011;
    #1;
    chk("unaligned_hit", 32'(bus.hit), 32'h0);
    chk("unaligned_rdata", bus.rdata, 32'h0);
    bus.addr = '0;

    // KEY0 press: accepted on the 6th edge
    keyRaw = 4'b1110;
    hold(5);
    peekc("press_early", KDATA, 32'h0);
    hold(1);
    peekc("press_kdata", KDATA, 32'h1);
    peekc("press_kctrl", KCTRL, 32'h1);
    load(KDATA);
    peekc("ready_clr", KCTRL, 32'h0);

    keyRaw = 4'hF;
    hold(6);
    peekc("release_kdata", KDATA, 32'h0);
    load(KDATA);

    // Bounce: low 3, high 1, low 6
    keyRaw = 4'b1110; hold(3);
    keyRaw = 4'b1111; hold(1);
    keyRaw = 4'b1110; hold(5);
    peekc("bounce_early", KDATA, 32'h0);
    hold(1);
    peekc("bounce_kdata", KDATA, 32'h1);
    peekc("bounce_kctrl", KCTRL, 32'h1);
    load(KDATA);
    keyRaw = 4'hF;
    hold(6);
    load(KDATA);

    // SW sequence without loads raises OVR; clearing store keeps READY
    swRaw = 10'h3FF; hold(10);
    swRaw = 10'h001; hold(10);
    peekc("sw_sdata", SDATA, 32'h1);
    peekc("sw_sctrl", SCTRL, 32'h5);
    store(SCTRL, 32'h0);
    peekc("sw_ovr_clr", SCTRL, 32'h1);
    store(SDATA, 32'hFFFF_FFFF);
    peek("sw_data_store", SDATA);

    // Change on the same edge as a KDATA load
    keyRaw = 4'b1110;
    hold(5);
    bus.addr = KDATA;
    bus.rdEn = 1'b1;
    #1;
    chk("same_edge_old", bus.rdata, 32'h0);
    step(1'b0, "");
    idle_bus();
    peekc("same_edge_kctrl", KCTRL, 32'h1);
    peekc("same_edge_kdata", KDATA, 32'h1);

    // Reset mid-count, then a full re-debounce is needed
    keyRaw = 4'hF; hold(6);
    peek("pre_rst_kctrl", KCTRL);
    keyRaw = 4'b1110; hold(3);
    reset = 1'b0;
    m_reset();
    peekc("midrst_kdata", KDATA, 32'h0);
    peekc("midrst_kctrl", KCTRL, 32'h0);
    hold(2);
    reset = 1'b1;
    hold(5);
    peekc("rerun_kctrl", KCTRL, 32'h0);
    peekc("rerun_kdata", KDATA, 32'h0);
    hold(1);
    peekc("rerun_done", KDATA, 32'h1);

    // Interrupt path (IE stays 0 in the default build)
    load(KDATA);
    store(KCTRL, 32'h100);
    peek("ie_kctrl", KCTRL);
    keyRaw = 4'hF;
    for (int i = 0; i < 8; i++) step(1'b1, "irq_seq");
    bus.addr = KDATA;
    bus.rdEn = 1'b1;
    step(1'b1, "irq_load");
    idle_bus();
    for (int i = 0; i < 2; i++) step(1'b1, "irq_after");
    store(KCTRL, 32'h0);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int b;
        b = $urandom_range(0, 13);
        if (b < 4) keyRaw[b] = ~keyRaw[b];
        else swRaw[b-4] = ~swRaw[b-4];
      end
      bus.addr  = addrs[$urandom_range(0, 5)];
      bus.rdEn  = ($urandom_range(0, 5) == 0);
      bus.wrEn  = ($urandom_range(0, 9) == 0);
      bus.wdata = $urandom;
      step(1'b1, "rand");
    end
    idle_bus();
    peek("final_kctrl", KCTRL);
    peek("final_sctrl", SCTRL);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
